// File: rtl/trackball_pkg.sv
// Shared types and packet layout for the trackball source arbiter.
// Source encoding doubles as the active_src output value.
package trackball_pkg;

   typedef enum logic [1:0] {
      SRC_IDLE    = 2'd0,
      SRC_MOUSE   = 2'd1,
      SRC_DIGITAL = 2'd2,
      SRC_ANALOG  = 2'd3
   } src_t;

   localparam int TOGGLE_BIT       = 24;
   localparam int DX_LSB           = 8;
   localparam int DX_MSB           = 15;
   localparam int DY_LSB           = 16;
   localparam int DY_MSB           = 23;
   localparam int SX_BIT           = 4;
   localparam int SY_BIT           = 5;
   localparam int DEFAULT_DEADZONE = 10;

   // |-128| must come out as 128, which still fits in 8 unsigned bits.
   function automatic logic [7:0] mag8(input logic [7:0] v);
      return v[7] ? (~v + 8'd1) : v;
   endfunction

endpackage

// File: rtl/trackball_activity_detect.sv
// Per-cycle activity terms for the three motion sources, including the
// mouse packet-toggle edge detector and its post-reset priming.
module trackball_activity_detect
   import trackball_pkg::*;
#(
   parameter int DEADZONE = DEFAULT_DEADZONE
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mouse_toggle,
   input  logic [7:0]  mouse_dx,
   input  logic [7:0]  mouse_dy,
   input  logic [3:0]  joystick_in,
   input  logic [15:0] joystick_analog_in,
   output logic        mouse_pkt,
   output logic        mouse_act,
   output logic        dig_act,
   output logic        ana_act
);

   localparam logic [8:0] DZ = 9'(DEADZONE);

   logic prev_toggle_q, prev_toggle_d;
   logic primed_q, primed_d;

   always_comb begin
      prev_toggle_d = mouse_toggle;
      primed_d      = 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prev_toggle_q <= 1'b0;
         primed_q      <= 1'b0;
      end else begin
         prev_toggle_q <= prev_toggle_d;
         primed_q      <= primed_d;
      end
   end

   // Until primed, a toggle level left over from before reset is not a packet.
   assign mouse_pkt = primed_q && (mouse_toggle != prev_toggle_q);
   assign mouse_act = mouse_pkt && ((mouse_dx != 8'd0) || (mouse_dy != 8'd0));
   assign dig_act   = (joystick_in != 4'd0);
   assign ana_act   = ({1'b0, mag8(joystick_analog_in[7:0])}  >= DZ) ||
                      ({1'b0, mag8(joystick_analog_in[15:8])} >= DZ);

endmodule

// File: rtl/trackball_source_arbiter.sv
// Grants the trackball emulator to the last active motion source and holds
// it until that source has been idle for HOLD_CYCLES; masks all others.
module trackball_source_arbiter
   import trackball_pkg::*;
#(
   parameter int HOLD_CYCLES = 3000000,
   parameter int DEADZONE    = DEFAULT_DEADZONE,
   parameter int TIMER_W     = 22
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [24:0] ps2_mouse_in,
   input  logic [3:0]  joystick_in,
   input  logic [15:0] joystick_analog_in,
   output logic [24:0] ps2_mouse_out,
   output logic [3:0]  joystick_out,
   output logic [15:0] joystick_analog_out,
   output logic        joystick_mode_out,
   output logic [1:0]  active_src
);

   localparam logic [TIMER_W-1:0] HOLD_RELOAD = TIMER_W'(HOLD_CYCLES - 1);

   logic mouse_pkt, mouse_act, dig_act, ana_act;
   logic own_act;

   src_t               state_q, state_d;
   logic [TIMER_W-1:0] cnt_q, cnt_d;
   logic [24:0]        mouse_out_q, mouse_out_d;
   logic [3:0]         joy_out_q, joy_out_d;
   logic [15:0]        ana_out_q, ana_out_d;
   logic               mode_q, mode_d;

   trackball_activity_detect #(
      .DEADZONE (DEADZONE)
   ) u_detect (
      .clk                (clk),
      .reset              (reset),
      .mouse_toggle       (ps2_mouse_in[TOGGLE_BIT]),
      .mouse_dx           (ps2_mouse_in[DX_MSB:DX_LSB]),
      .mouse_dy           (ps2_mouse_in[DY_MSB:DY_LSB]),
      .joystick_in        (joystick_in),
      .joystick_analog_in (joystick_analog_in),
      .mouse_pkt          (mouse_pkt),
      .mouse_act          (mouse_act),
      .dig_act            (dig_act),
      .ana_act            (ana_act)
   );

   always_comb begin
      unique case (state_q)
         SRC_MOUSE:   own_act = mouse_act;
         SRC_DIGITAL: own_act = dig_act;
         SRC_ANALOG:  own_act = ana_act;
         default:     own_act = 1'b0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (state_q == SRC_IDLE) begin
         if (mouse_act) begin
            state_d = SRC_MOUSE;
            cnt_d   = HOLD_RELOAD;
         end else if (dig_act) begin
            state_d = SRC_DIGITAL;
            cnt_d   = HOLD_RELOAD;
         end else if (ana_act) begin
            state_d = SRC_ANALOG;
            cnt_d   = HOLD_RELOAD;
         end
      end else if (own_act) begin
         cnt_d = HOLD_RELOAD;
      end else if (cnt_q == '0) begin
         state_d = SRC_IDLE;
      end else begin
         cnt_d = cnt_q - TIMER_W'(1);
      end

      // Outputs follow the next owner so grant/release and data move together.
      mouse_out_d = mouse_out_q;
      if ((state_d == SRC_MOUSE) && mouse_pkt)
         mouse_out_d = {~mouse_out_q[TOGGLE_BIT], ps2_mouse_in[23:0]};
      joy_out_d = (state_d == SRC_DIGITAL) ? joystick_in : 4'd0;
      ana_out_d = (state_d == SRC_ANALOG) ? joystick_analog_in : 16'd0;
      mode_d    = (state_d == SRC_ANALOG);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= SRC_IDLE;
         cnt_q       <= '0;
         mouse_out_q <= '0;
         joy_out_q   <= '0;
         ana_out_q   <= '0;
         mode_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         mouse_out_q <= mouse_out_d;
         joy_out_q   <= joy_out_d;
         ana_out_q   <= ana_out_d;
         mode_q      <= mode_d;
      end
   end

   assign ps2_mouse_out       = mouse_out_q;
   assign joystick_out        = joy_out_q;
   assign joystick_analog_out = ana_out_q;
   assign joystick_mode_out   = mode_q;
   assign active_src          = state_q;

endmodule
